// File: rtl/digital_port_pkg.sv
// Shared bus definitions for the memory-mapped digital I/O ports:
// base addresses, register offsets and the direction-bit encoding.
package digital_port_pkg;

  localparam logic [31:0] PORT_A_BASE  = 32'hF000_0000;
  localparam logic [31:0] PORT_B_BASE  = 32'hF000_0008;

  localparam logic [31:0] OFFSET_VALUE = 32'h0000_0000;
  localparam logic [31:0] OFFSET_DIR   = 32'h0000_0004;

  // A set direction bit makes the pin an output.
  localparam logic DIR_OUT = 1'b1;

  // Absolute bus address of a port register.
  function automatic logic [31:0] regAddr(input logic [31:0] base, input logic [31:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/digital_port_sync2.sv
// Two-flop synchronizer for asynchronous pin inputs; clears to zero on reset.
module sync2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] syncA;
  logic [WIDTH-1:0] syncB;

  // Shift the raw pin sample through two flop stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncA <= {WIDTH{1'b0}};
      syncB <= {WIDTH{1'b0}};
    end else begin
      syncA <= d;
      syncB <= syncA;
    end
  end

  assign q = syncB;

endmodule

// File: rtl/digital_port.sv
// Bidirectional I/O port: output-value and direction registers, per-pin
// tri-state drivers, and a read mux returning driven bits for outputs and
// synchronized pin values for inputs.
module digital_port
  import digital_port_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chipSelect,
  input  logic             writeIO,
  input  logic             writeDirection,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  inout  wire  [WIDTH-1:0] IO
);

  localparam logic [WIDTH-1:0] OUT_RESET = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] DIR_RESET = {WIDTH{1'b0}};

  logic [WIDTH-1:0] outReg;
  logic [WIDTH-1:0] dirReg;
  logic [WIDTH-1:0] pinSync;
  logic [WIDTH-1:0] readMux;

  // Load the value and direction registers on chip-selected strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outReg <= OUT_RESET;
      dirReg <= DIR_RESET;
    end else begin
      if (chipSelect && writeIO) begin
        outReg <= dataIn;
      end
      if (chipSelect && writeDirection) begin
        dirReg <= dataIn;
      end
    end
  end

  // Each pin is driven only while its direction bit selects output.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign IO[i] = (dirReg[i] == DIR_OUT) ? outReg[i] : 1'bz;
  end

  sync2 #(
    .WIDTH(WIDTH)
  ) u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (IO),
    .q   (pinSync)
  );

  // Read back driven bits from outReg and input bits from the synchronizer.
  always_comb begin
    readMux = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (dirReg[i] == DIR_OUT) begin
        readMux[i] = outReg[i];
      end else begin
        readMux[i] = pinSync[i];
      end
    end
  end

  assign dataOut = readMux;

endmodule

// File: tb/tb_digital_port.sv
// Directed, table-driven bench for digital_port with hand-written sequences
// for reset, write readback latency and input synchronizer latency.
module tb_digital_port;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          chipSelect;
  logic          writeIO;
  logic          writeDirection;
  logic [W-1:0]  dataIn;
  logic [W-1:0]  dataOut;
  wire  [W-1:0]  IO;

  logic [W-1:0]  pinEn;
  logic [W-1:0]  pinVal;

  int checks;
  int errors;

  digital_port #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .chipSelect     (chipSelect),
    .writeIO        (writeIO),
    .writeDirection (writeDirection),
    .dataIn         (dataIn),
    .dataOut        (dataOut),
    .IO             (IO)
  );

  // External pin drivers on the bench side.
  for (genvar i = 0; i < W; i++) begin : g_ext
    assign IO[i] = pinEn[i] ? pinVal[i] : 1'bz;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         cs;
    logic         wio;
    logic         wdir;
    logic [W-1:0] data;
    logic [W-1:0] en;
    logic [W-1:0] val;
    logic [W-1:0] expData;
    logic [W-1:0] expIo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    chipSelect = 1'b0;
    writeIO = 1'b0;
    writeDirection = 1'b0;
    dataIn = 32'h0;
    pinEn = 32'h0;
    pinVal = 32'h0;

    //                cs    wio   wdir  data          pinEn         pinVal        expData       expIo
    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h00000000, 32'h00000000, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000FFFF, 32'hFFFF0000, 32'hBEEF0000, 32'hBEEFA5A5, 32'hBEEFA5A5};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h12345678, 32'hFFFF0000, 32'hBEEF0000, 32'hBEEF5678, 32'hBEEF5678};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFF0000, 32'hBEEF0000, 32'hBEEF5678, 32'hBEEF5678};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h00000000, 32'hFFFF0000, 32'hBEEF0000, 32'hBEEF5678, 32'hBEEF5678};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 32'hFFFF0000, 32'hBEEF0000, 32'hBEEF5678, 32'hBEEF5678};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h000000FF, 32'hFFFFFF00, 32'h12345600, 32'h123456FF, 32'h123456FF};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h000000FF, 32'h000000FF};

    // Reset: strobes during reset are lost, dataOut stays zero.
    pinEn = 32'hFFFFFFFF;
    pinVal = 32'h5A5A5A5A;
    chipSelect = 1'b1;
    writeIO = 1'b1;
    writeDirection = 1'b1;
    dataIn = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dataOut", dataOut, 32'h00000000);
    chipSelect = 1'b0;
    writeIO = 1'b0;
    writeDirection = 1'b0;
    dataIn = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pins_are_inputs", dataOut, 32'h5A5A5A5A);
    pinEn = 32'h0;

    // Table-driven register writes and readback.
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      chipSelect = vecs[v].cs;
      writeIO = vecs[v].wio;
      writeDirection = vecs[v].wdir;
      dataIn = vecs[v].data;
      @(posedge clk);
      #1;
      chipSelect = 1'b0;
      writeIO = 1'b0;
      writeDirection = 1'b0;
      pinEn = vecs[v].en;
      pinVal = vecs[v].val;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_dataOut", v), dataOut, vecs[v].expData);
      check($sformatf("vec%0d_IO", v), IO, vecs[v].expIo);
    end

    // Output readback is visible right after the write edge.
    @(negedge clk);
    chipSelect = 1'b1;
    writeIO = 1'b1;
    dataIn = 32'h3C3C3C3C;
    @(posedge clk);
    #1;
    chipSelect = 1'b0;
    writeIO = 1'b0;
    check("write_latency_dataOut", dataOut, 32'h3C3C3C3C);
    check("write_latency_IO", IO, 32'h3C3C3C3C);

    // Input synchronizer latency and asynchronous reset clearing dataOut.
    @(negedge clk);
    chipSelect = 1'b1;
    writeDirection = 1'b1;
    dataIn = 32'h00000000;
    @(posedge clk);
    #1;
    chipSelect = 1'b0;
    writeDirection = 1'b0;
    pinEn = 32'hFFFFFFFF;
    pinVal = 32'h00000000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sync_idle", dataOut, 32'h00000000);
    pinVal = 32'h00000001;
    @(posedge clk);
    #1;
    check("sync_after_1_edge", dataOut, 32'h00000000);
    @(posedge clk);
    #1;
    check("sync_after_2_edges", dataOut, 32'h00000001);
    rst = 1'b0;
    #1;
    check("async_reset_clears", dataOut, 32'h00000000);
    @(negedge clk);
    rst = 1'b1;
    pinEn = 32'h0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
